// File: rtl/bomb_field_ctrl.sv
// Grid bomb engine: placement, fuse, blast arm painting and flash for NP players.
// Optional build macro BOMB_CHAIN_EN: an arm landing on a live bomb detonates it one cycle later.
module bomb_field_ctrl #(
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 16,
  parameter int unsigned NP     = 2,
  parameter int unsigned CAP    = 4,
  parameter int unsigned LEN_W  = 2,
  parameter int unsigned FUSE   = 60,
  parameter int unsigned FLASH  = 18,
  localparam int unsigned N     = GRID_W * GRID_H,
  localparam int unsigned AW    = $clog2(N),
  localparam int unsigned CW    = $clog2(CAP + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NP-1:0]       put,
  input  logic [NP*AW-1:0]    put_cor,
  input  logic [NP*LEN_W-1:0] put_len,
  input  logic [2*N-1:0]      wall_grid,
  output logic [NP-1:0]       put_ack,
  output logic [3*N-1:0]      bomb_tile,
  output logic [N-1:0]        explode,
  output logic [N-1:0]        bomb_un_grid,
  output logic [N-1:0]        wall_hit,
  output logic [NP*CW-1:0]    bomb_num
);
  localparam int unsigned MAXR = 2 ** LEN_W;
  localparam int unsigned CTW  = $clog2((FUSE > FLASH) ? FUSE : FLASH);
  localparam int unsigned OW   = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [1:0] W_EMPTY  = 2'd0;
  localparam logic [1:0] W_ABLE   = 2'd1;
  localparam logic [1:0] W_UNABLE = 2'd2;

  typedef enum logic [2:0] {
    T_EMPTY = 3'd0,
    T_BOMB  = 3'd2,
    T_UP    = 3'd3,
    T_DOWN  = 3'd4,
    T_LEFT  = 3'd5,
    T_RIGHT = 3'd6,
    T_CEN   = 3'd7
  } tile_t;

  tile_t            st_q   [N];
  tile_t            st_d   [N];
  logic [CTW-1:0]   ctr_q  [N];
  logic [CTW-1:0]   ctr_d  [N];
  logic [OW-1:0]    own_q  [N];
  logic [OW-1:0]    own_d  [N];
  logic [LEN_W-1:0] len_q  [N];
  logic [LEN_W-1:0] len_d  [N];
  logic [CW-1:0]    bn_q   [NP];
  logic [CW-1:0]    bn_d   [NP];
  logic [NP-1:0]    ack_q;
  logic [N-1:0]     hit_q;
  logic [N-1:0]     hit_d;
`ifdef BOMB_CHAIN_EN
  logic [N-1:0]     chain_q;
  logic [N-1:0]     chain_d;
`endif

  logic [1:0]       wall    [N];
  logic [N-1:0]     det;
  logic [3:0]       arm     [N];
  logic [NP-1:0]    acc;
  logic [AW-1:0]    acc_cor [NP];

  function automatic tile_t dir_of(input logic [3:0] a);
    if (a[0])      return T_UP;
    else if (a[1]) return T_DOWN;
    else if (a[2]) return T_LEFT;
    else           return T_RIGHT;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(N); i++) wall[i] = wall_grid[2*i +: 2];
  end

  // Bombs detonating at the coming edge
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      det[i] = (st_q[i] == T_BOMB) && (ctr_q[i] == CTW'(FUSE - 1));
`ifdef BOMB_CHAIN_EN
      if ((st_q[i] == T_BOMB) && chain_q[i]) det[i] = 1'b1;
`endif
    end
  end

  // Arms seen from the target tile: scan outward for a detonating source within its radius.
  // Bit order 0..3 = UP, DOWN, LEFT, RIGHT; an UP arm comes from a source below the target.
  always_comb begin
    int  r;
    int  c;
    int  src;
    logic blk;
    logic inb;
    r = 0; c = 0; src = 0; blk = 1'b0; inb = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      arm[i] = 4'b0000;
      r = i / int'(GRID_W);
      c = i % int'(GRID_W);
      if (wall[i] != W_UNABLE) begin
        for (int d = 0; d < 4; d++) begin
          blk = 1'b0;
          for (int s = 1; s <= int'(MAXR); s++) begin
            case (d)
              0:       begin inb = (r + s) < int'(GRID_H); src = i + s * int'(GRID_W); end
              1:       begin inb = (r - s) >= 0;           src = i - s * int'(GRID_W); end
              2:       begin inb = (c + s) < int'(GRID_W); src = i + s;                end
              default: begin inb = (c - s) >= 0;           src = i - s;                end
            endcase
            if (!blk && inb) begin
              if (det[AW'(src)] && ((int'(len_q[AW'(src)]) + 1) >= s)) arm[i][d] = 1'b1;
              if (wall[AW'(src)] != W_EMPTY) blk = 1'b1;
            end
          end
        end
      end
    end
  end

  // Put arbitration: a tile being painted this edge is not free; lowest player wins a tie
  always_comb begin
    acc = '0;
    for (int p = 0; p < int'(NP); p++) begin
      acc_cor[p] = put_cor[p*AW +: AW];
      if (put[p] && (32'(acc_cor[p]) < N) && (st_q[acc_cor[p]] == T_EMPTY) &&
          (wall[acc_cor[p]] == W_EMPTY) && !(|arm[acc_cor[p]]) && (bn_q[p] < CW'(CAP))) begin
        acc[p] = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (acc[q] && (acc_cor[q] == acc_cor[p])) acc[p] = 1'b0;
        end
      end
    end
  end

  // Per-tile next state and per-player live counts
  always_comb begin
    int dec [NP];
    for (int p = 0; p < int'(NP); p++) dec[p] = 0;
    for (int i = 0; i < int'(N); i++) begin
      st_d[i]  = st_q[i];
      ctr_d[i] = ctr_q[i];
      own_d[i] = own_q[i];
      len_d[i] = len_q[i];
      hit_d[i] = (|arm[i]) && (wall[i] == W_ABLE);
`ifdef BOMB_CHAIN_EN
      chain_d[i] = 1'b0;
`endif
      if (det[i]) begin
        st_d[i]  = T_CEN;
        ctr_d[i] = '0;
        dec[own_q[i]]++;
      end else begin
        case (st_q[i])
          T_EMPTY: begin
            if (|arm[i]) begin
              st_d[i]  = dir_of(arm[i]);
              ctr_d[i] = '0;
            end
          end
          T_BOMB: begin
            ctr_d[i] = ctr_q[i] + CTW'(1);
`ifdef BOMB_CHAIN_EN
            chain_d[i] = |arm[i];
`endif
          end
          T_CEN: begin
            if (ctr_q[i] == CTW'(FLASH - 1)) begin
              st_d[i]  = T_EMPTY;
              ctr_d[i] = '0;
            end else begin
              ctr_d[i] = ctr_q[i] + CTW'(1);
            end
          end
          default: begin
            if (|arm[i]) begin
              st_d[i]  = dir_of(arm[i]);
              ctr_d[i] = '0;
            end else if (ctr_q[i] == CTW'(FLASH - 1)) begin
              st_d[i]  = T_EMPTY;
              ctr_d[i] = '0;
            end else begin
              ctr_d[i] = ctr_q[i] + CTW'(1);
            end
          end
        endcase
      end
    end
    for (int p = 0; p < int'(NP); p++) begin
      if (acc[p]) begin
        st_d[acc_cor[p]]  = T_BOMB;
        ctr_d[acc_cor[p]] = '0;
        own_d[acc_cor[p]] = OW'(p);
        len_d[acc_cor[p]] = put_len[p*LEN_W +: LEN_W];
      end
      bn_d[p] = CW'(int'(bn_q[p]) + int'(acc[p]) - dec[p]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) begin
        st_q[i]  <= T_EMPTY;
        ctr_q[i] <= '0;
        own_q[i] <= '0;
        len_q[i] <= '0;
      end
      for (int p = 0; p < int'(NP); p++) bn_q[p] <= '0;
      ack_q <= '0;
      hit_q <= '0;
`ifdef BOMB_CHAIN_EN
      chain_q <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        st_q[i]  <= st_d[i];
        ctr_q[i] <= ctr_d[i];
        own_q[i] <= own_d[i];
        len_q[i] <= len_d[i];
      end
      for (int p = 0; p < int'(NP); p++) bn_q[p] <= bn_d[p];
      ack_q <= acc;
      hit_q <= hit_d;
`ifdef BOMB_CHAIN_EN
      chain_q <= chain_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      bomb_tile[3*i +: 3] = st_q[i];
      explode[i]          = (st_q[i] >= T_UP);
      bomb_un_grid[i]     = (st_q[i] == T_BOMB);
    end
    for (int p = 0; p < int'(NP); p++) bomb_num[p*CW +: CW] = bn_q[p];
  end

  assign put_ack  = ack_q;
  assign wall_hit = hit_q;

endmodule

// File: tb/tb_bomb_field_ctrl.sv
// Directed bench for bomb_field_ctrl on the default 16x16, two-player configuration.
module tb_bomb_field_ctrl;
  localparam int unsigned N     = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned NP    = 2;
  localparam int unsigned LEN_W = 2;
  localparam int unsigned CW    = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NP-1:0]       put;
  logic [NP*AW-1:0]    put_cor;
  logic [NP*LEN_W-1:0] put_len;
  logic [2*N-1:0]      wall_grid;
  logic [NP-1:0]       put_ack;
  logic [3*N-1:0]      bomb_tile;
  logic [N-1:0]        explode;
  logic [N-1:0]        bomb_un_grid;
  logic [N-1:0]        wall_hit;
  logic [NP*CW-1:0]    bomb_num;

  int checks = 0;
  int errors = 0;

  bomb_field_ctrl #(
    .GRID_W(16), .GRID_H(16), .NP(2), .CAP(4), .LEN_W(2), .FUSE(60), .FLASH(18)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .put          (put),
    .put_cor      (put_cor),
    .put_len      (put_len),
    .wall_grid    (wall_grid),
    .put_ack      (put_ack),
    .bomb_tile    (bomb_tile),
    .explode      (explode),
    .bomb_un_grid (bomb_un_grid),
    .wall_hit     (wall_hit),
    .bomb_num     (bomb_num)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tile(input int i);
    return 32'(bomb_tile[3*i +: 3]);
  endfunction

  function automatic logic [31:0] bnum(input int p);
    return 32'(bomb_num[p*CW +: CW]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    put = '0; put_cor = '0; put_len = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic req(input int p, input int cor, input int len);
    put[p] = 1'b1;
    put_cor[p*AW +: AW] = AW'(cor);
    put_len[p*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // Inputs change and outputs are sampled on the falling edge; "nK" = state after the K-th rising edge from the put.
  initial begin
    wall_grid = '0;
    do_reset();
    check("rst_tile17", tile(17), 0);
    check("rst_bnum0", bnum(0), 0);
    check("rst_ack", 32'(put_ack), 0);
    check("rst_hit", 32'(|wall_hit), 0);

    // Single bomb, radius 1, full fuse and flash timing
    req(0, 17, 0);
    step(1);
    check("t1_ack", 32'(put_ack), 1);
    check("t1_bomb", tile(17), 2);
    check("t1_bomb_un", 32'(bomb_un_grid[17]), 1);
    check("t1_bnum", bnum(0), 1);
    put = '0;
    step(1);
    check("t1_ack_pulse", 32'(put_ack), 0);
    step(58);
    check("t1_fuse_end", tile(17), 2);
    step(1);
    check("t1_cen", tile(17), 7);
    check("t1_up", tile(1), 3);
    check("t1_down", tile(33), 4);
    check("t1_left", tile(16), 5);
    check("t1_right", tile(18), 6);
    check("t1_no_r2", tile(2), 0);
    check("t1_explode", 32'(explode[17]), 1);
    check("t1_bnum_dec", bnum(0), 0);
    step(17);
    check("t1_flash_end", tile(17), 7);
    step(1);
    check("t1_empty_cen", tile(17), 0);
    check("t1_empty_up", tile(1), 0);

    // Right grid edge, radius 4
    do_reset();
    req(0, 15, 3);
    step(1);
    put = '0;
    step(60);
    check("t2_cen", tile(15), 7);
    check("t2_left1", tile(14), 5);
    check("t2_left4", tile(11), 5);
    check("t2_left5", tile(10), 0);
    check("t2_no_wrap", tile(16), 0);
    check("t2_down4", tile(79), 4);

    // Destructible wall on the right arm, solid wall on the down arm
    wall_grid[2*19 +: 2] = 2'd1;
    wall_grid[2*49 +: 2] = 2'd2;
    do_reset();
    req(0, 17, 3);
    step(1);
    put = '0;
    step(60);
    check("t3_r18", tile(18), 6);
    check("t3_r19", tile(19), 6);
    check("t3_r20", tile(20), 0);
    check("t3_hit19", 32'(wall_hit[19]), 1);
    check("t3_hit18", 32'(wall_hit[18]), 0);
    check("t3_d33", tile(33), 4);
    check("t3_d49", tile(49), 0);
    check("t3_d65", tile(65), 0);
    check("t3_up1", tile(1), 3);
    check("t3_left16", tile(16), 5);
    step(1);
    check("t3_hit_pulse", 32'(wall_hit[19]), 0);
    wall_grid = '0;

    // Capacity: four accepted, fifth rejected, room again after first detonation
    do_reset();
    req(0, 100, 0);
    step(1);
    check("t4_ack1", 32'(put_ack), 1);
    req(0, 102, 0);
    step(1);
    check("t4_ack2", 32'(put_ack), 1);
    req(0, 104, 0);
    step(1);
    check("t4_ack3", 32'(put_ack), 1);
    req(0, 106, 0);
    step(1);
    check("t4_ack4", 32'(put_ack), 1);
    check("t4_bnum4", bnum(0), 4);
    req(0, 108, 0);
    step(1);
    check("t4_ack5", 32'(put_ack), 0);
    check("t4_tile108", tile(108), 0);
    check("t4_bnum_cap", bnum(0), 4);
    put = '0;
    step(56);
    check("t4_first_det", tile(100), 7);
    check("t4_bnum3", bnum(0), 3);
    req(0, 120, 0);
    step(1);
    check("t4_ack_again", 32'(put_ack), 1);
    check("t4_tile120", tile(120), 2);
    check("t4_bnum_net", bnum(0), 3);
    put = '0;

    // Reset mid-fuse, then same-tile contention between players
    do_reset();
    check("t5_rst_tile", tile(102), 0);
    check("t5_rst_bnum", bnum(0), 0);
    req(0, 50, 0);
    req(1, 50, 0);
    step(1);
    check("t5_ack", 32'(put_ack), 1);
    check("t5_tile", tile(50), 2);
    check("t5_bnum0", bnum(0), 1);
    check("t5_bnum1", bnum(1), 0);
    put[0] = 1'b0;
    step(1);
    check("t5_busy_ack", 32'(put_ack), 0);
    check("t5_busy_bnum1", bnum(1), 0);
    put = '0;

    // Two bombs in reach of each other, ten cycles apart
    do_reset();
    req(0, 17, 1);
    step(1);
    check("t6_ack17", 32'(put_ack), 1);
    put = '0;
    step(9);
    req(0, 19, 1);
    step(1);
    check("t6_ack19", 32'(put_ack), 1);
    put = '0;
    step(50);
    check("t6_cen17", tile(17), 7);
    check("t6_r18", tile(18), 6);
    check("t6_skip19", tile(19), 2);
    check("t6_r20", tile(20), 0);
    step(1);
`ifdef BOMB_CHAIN_EN
    check("t6_chain19", tile(19), 7);
    check("t6_chain18", tile(18), 5);
    check("t6_chain_bnum", bnum(0), 0);
`else
    check("t6_own19", tile(19), 2);
    check("t6_keep18", tile(18), 6);
    check("t6_own_bnum", bnum(0), 1);
`endif
    step(9);
    check("t6_19_cen", tile(19), 7);
    check("t6_bnum_end", bnum(0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
